// File: rtl/tk1_spi_seq_pkg.sv
// Shared types for the tk1 SPI flash command sequencer: FSM states, byte phases,
// common flash opcodes and the phase-advance rule.
package tk1_spi_seq_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CS_ON,
      ST_LOAD,
      ST_START,
      ST_WAIT,
      ST_RXOUT,
      ST_NEXT,
      ST_CS_OFF,
      ST_DONE
   } state_e;

   typedef enum logic [2:0] {
      PH_OPCODE,
      PH_ADDR2,
      PH_ADDR1,
      PH_ADDR0,
      PH_DUMMY,
      PH_DATA
   } phase_e;

   localparam logic [7:0] OP_READ       = 8'h03;
   localparam logic [7:0] OP_FAST_READ  = 8'h0B;
   localparam logic [7:0] OP_WREN       = 8'h06;
   localparam logic [7:0] OP_RDID       = 8'h9F;
   localparam logic [7:0] OP_RELEASE_PD = 8'hAB;

   typedef struct packed {
      phase_e phase;
      logic   more;
   } phase_step_t;

   // cnt_gt1 decides whether another DATA byte follows the one just finished.
   function automatic phase_step_t next_phase(input phase_e ph,
                                              input logic   addr_en,
                                              input logic   dummy,
                                              input logic   cnt_nz,
                                              input logic   cnt_gt1);
      phase_step_t s;
      s.phase = ph;
      s.more  = 1'b1;
      case (ph)
         PH_OPCODE: begin
            if (addr_en)     s.phase = PH_ADDR2;
            else if (dummy)  s.phase = PH_DUMMY;
            else if (cnt_nz) s.phase = PH_DATA;
            else             s.more  = 1'b0;
         end
         PH_ADDR2: s.phase = PH_ADDR1;
         PH_ADDR1: s.phase = PH_ADDR0;
         PH_ADDR0: begin
            if (dummy)       s.phase = PH_DUMMY;
            else if (cnt_nz) s.phase = PH_DATA;
            else             s.more  = 1'b0;
         end
         PH_DUMMY: begin
            if (cnt_nz) s.phase = PH_DATA;
            else        s.more  = 1'b0;
         end
         default: s.more = cnt_gt1;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/tk1_spi_seq_phase.sv
// Combinational byte select: picks the byte to shift out for the current phase.
module tk1_spi_seq_phase
   import tk1_spi_seq_pkg::*;
(
   input  phase_e      phase,
   input  logic [7:0]  opcode,
   input  logic [23:0] addr,
   output logic [7:0]  tx_byte
);

   always_comb begin
      case (phase)
         PH_OPCODE: tx_byte = opcode;
         PH_ADDR2:  tx_byte = addr[23:16];
         PH_ADDR1:  tx_byte = addr[15:8];
         PH_ADDR0:  tx_byte = addr[7:0];
         default:   tx_byte = 8'h00;
      endcase
   end

endmodule

// File: rtl/tk1_spi_flash_seq.sv
// Flash command sequencer driving tk1_spi_master byte by byte.
// Optional dummy-byte phase is built only when TK1_SPI_SEQ_DUMMY_EN is defined.
module tk1_spi_flash_seq
   import tk1_spi_seq_pkg::*;
#(
   parameter int unsigned LEN_W = 8
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             fw_app_mode,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [7:0]       cmd_opcode,
   input  logic             cmd_addr_en,
   input  logic [23:0]      cmd_addr,
   input  logic             cmd_dummy,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic [7:0]       rx_data,
   output logic             busy,
   output logic             done,
   output logic             spi_enable,
   output logic             spi_enable_vld,
   output logic             spi_start,
   output logic [7:0]       spi_tx_data,
   output logic             spi_tx_data_vld,
   input  logic             spi_ready,
   input  logic [7:0]       spi_rx_data
);

   state_e           state_q, state_d;
   phase_e           phase_q, phase_d;
   logic [7:0]       opcode_q, opcode_d;
   logic [23:0]      addr_q, addr_d;
   logic             addr_en_q, addr_en_d;
   logic             dummy_q;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             wait_armed_q, wait_armed_d;

   logic             spi_enable_q, spi_enable_d;
   logic             spi_enable_vld_q, spi_enable_vld_d;
   logic             spi_start_q, spi_start_d;
   logic [7:0]       spi_tx_data_q, spi_tx_data_d;
   logic             spi_tx_data_vld_q, spi_tx_data_vld_d;
   logic             rx_valid_q, rx_valid_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             done_q, done_d;

   phase_step_t      step;
   phase_e           sel_phase;
   logic [7:0]       tx_byte;

`ifdef TK1_SPI_SEQ_DUMMY_EN
   logic dummy_d;
`else
   logic unused_cmd_dummy;
   assign unused_cmd_dummy = cmd_dummy;
   assign dummy_q          = 1'b0;
`endif

   assign step = next_phase(phase_q, addr_en_q, dummy_q,
                            cnt_q != '0, cnt_q > LEN_W'(1));

   // In NEXT the byte being loaded belongs to the phase we are advancing into.
   assign sel_phase = (state_q == ST_NEXT) ? step.phase : phase_q;

   tk1_spi_seq_phase u_phase (
      .phase   (sel_phase),
      .opcode  (opcode_q),
      .addr    (addr_q),
      .tx_byte (tx_byte)
   );

   assign cmd_ready = (state_q == ST_IDLE) && !fw_app_mode;

   always_comb begin
      // NOTE: every _d starts from a default so no branch can leave one unassigned and infer a latch.
      state_d           = state_q;
      phase_d           = phase_q;
      opcode_d          = opcode_q;
      addr_d            = addr_q;
      addr_en_d         = addr_en_q;
      cnt_d             = cnt_q;
      wait_armed_d      = wait_armed_q;
      spi_enable_d      = spi_enable_q;
      spi_enable_vld_d  = 1'b0;
      spi_start_d       = 1'b0;
      spi_tx_data_d     = spi_tx_data_q;
      spi_tx_data_vld_d = 1'b0;
      rx_valid_d        = rx_valid_q;
      rx_data_d         = rx_data_q;
      done_d            = 1'b0;
`ifdef TK1_SPI_SEQ_DUMMY_EN
      dummy_d           = dummy_q;
`endif

      // Outputs are set on the transition into the state that owns them.
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               opcode_d         = cmd_opcode;
               addr_d           = cmd_addr;
               addr_en_d        = cmd_addr_en;
               cnt_d            = cmd_len;
               phase_d          = PH_OPCODE;
`ifdef TK1_SPI_SEQ_DUMMY_EN
               dummy_d          = cmd_dummy;
`endif
               spi_enable_d     = 1'b1;
               spi_enable_vld_d = 1'b1;
               state_d          = ST_CS_ON;
            end
         end
         ST_CS_ON: begin
            spi_tx_data_d     = tx_byte;
            spi_tx_data_vld_d = 1'b1;
            state_d           = ST_LOAD;
         end
         ST_LOAD: begin
            spi_start_d = 1'b1;
            state_d     = ST_START;
         end
         ST_START: begin
            wait_armed_d = 1'b0;
            state_d      = ST_WAIT;
         end
         ST_WAIT: begin
            if (!wait_armed_q) begin
               wait_armed_d = 1'b1;
            end else if (spi_ready) begin
               if (phase_q == PH_DATA) begin
                  rx_data_d  = spi_rx_data;
                  rx_valid_d = 1'b1;
                  state_d    = ST_RXOUT;
               end else begin
                  state_d = ST_NEXT;
               end
            end
         end
         ST_RXOUT: begin
            if (rx_ready) begin
               rx_valid_d = 1'b0;
               state_d    = ST_NEXT;
            end
         end
         ST_NEXT: begin
            if (phase_q == PH_DATA) cnt_d = cnt_q - LEN_W'(1);
            if (step.more) begin
               phase_d           = step.phase;
               spi_tx_data_d     = tx_byte;
               spi_tx_data_vld_d = 1'b1;
               state_d           = ST_LOAD;
            end else begin
               spi_enable_d     = 1'b0;
               spi_enable_vld_d = 1'b1;
               state_d          = ST_CS_OFF;
            end
         end
         ST_CS_OFF: begin
            done_d  = 1'b1;
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
      if (!reset_n) begin
         state_q           <= ST_IDLE;
         phase_q           <= PH_OPCODE;
         // NOTE: captured command fields are reset too, keeping X out of the tx byte mux.
         opcode_q          <= '0;
         addr_q            <= '0;
         addr_en_q         <= 1'b0;
         cnt_q             <= '0;
         wait_armed_q      <= 1'b0;
         spi_enable_q      <= 1'b0;
         spi_enable_vld_q  <= 1'b0;
         spi_start_q       <= 1'b0;
         spi_tx_data_q     <= '0;
         spi_tx_data_vld_q <= 1'b0;
         rx_valid_q        <= 1'b0;
         rx_data_q         <= '0;
         done_q            <= 1'b0;
`ifdef TK1_SPI_SEQ_DUMMY_EN
         dummy_q           <= 1'b0;
`endif
      end else begin
         state_q           <= state_d;
         phase_q           <= phase_d;
         opcode_q          <= opcode_d;
         addr_q            <= addr_d;
         addr_en_q         <= addr_en_d;
         cnt_q             <= cnt_d;
         wait_armed_q      <= wait_armed_d;
         spi_enable_q      <= spi_enable_d;
         spi_enable_vld_q  <= spi_enable_vld_d;
         spi_start_q       <= spi_start_d;
         spi_tx_data_q     <= spi_tx_data_d;
         spi_tx_data_vld_q <= spi_tx_data_vld_d;
         rx_valid_q        <= rx_valid_d;
         rx_data_q         <= rx_data_d;
         done_q            <= done_d;
`ifdef TK1_SPI_SEQ_DUMMY_EN
         dummy_q           <= dummy_d;
`endif
      end
   end

   assign busy            = (state_q != ST_IDLE);
   assign done            = done_q;
   assign spi_enable      = spi_enable_q;
   assign spi_enable_vld  = spi_enable_vld_q;
   assign spi_start       = spi_start_q;
   assign spi_tx_data     = spi_tx_data_q;
   assign spi_tx_data_vld = spi_tx_data_vld_q;
   assign rx_valid        = rx_valid_q;
   assign rx_data         = rx_data_q;

endmodule

// File: tb/tb_tk1_spi_flash_seq.sv
// Bench for tk1_spi_flash_seq: SPI master + flash model, reference command model,
// directed scenarios then randomized commands.
module tb_tk1_spi_flash_seq;

   localparam int LEN_W = 8;
   localparam int B     = 16;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             fw_app_mode;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [7:0]       cmd_opcode;
   logic             cmd_addr_en;
   logic [23:0]      cmd_addr;
   logic             cmd_dummy;
   logic [LEN_W-1:0] cmd_len;
   logic             rx_valid;
   logic             rx_ready;
   logic [7:0]       rx_data;
   logic             busy;
   logic             done;
   logic             spi_enable;
   logic             spi_enable_vld;
   logic             spi_start;
   logic [7:0]       spi_tx_data;
   logic             spi_tx_data_vld;
   logic             spi_ready = 1'b1;
   logic [7:0]       spi_rx_data = 8'h00;

   always #5 clk = ~clk;

   tk1_spi_flash_seq #(.LEN_W(LEN_W)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .fw_app_mode     (fw_app_mode),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_opcode      (cmd_opcode),
      .cmd_addr_en     (cmd_addr_en),
      .cmd_addr        (cmd_addr),
      .cmd_dummy       (cmd_dummy),
      .cmd_len         (cmd_len),
      .rx_valid        (rx_valid),
      .rx_ready        (rx_ready),
      .rx_data         (rx_data),
      .busy            (busy),
      .done            (done),
      .spi_enable      (spi_enable),
      .spi_enable_vld  (spi_enable_vld),
      .spi_start       (spi_start),
      .spi_tx_data     (spi_tx_data),
      .spi_tx_data_vld (spi_tx_data_vld),
      .spi_ready       (spi_ready),
      .spi_rx_data     (spi_rx_data)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

`ifdef TK1_SPI_SEQ_DUMMY_EN
   localparam bit DUMMY_EN = 1'b1;
`else
   localparam bit DUMMY_EN = 1'b0;
`endif

   // Flash model: READ/FAST_READ return memory contents, anything else a position pattern.
   logic [7:0] mem [256];

   function automatic logic [7:0] fpat(input int p);
      return 8'((p * 29 + 90) & 255);
   endfunction

   logic [7:0] tx_hist[$];
   logic [7:0] rx_q[$];
   logic [7:0] tx_latch;
   logic [7:0] rx_next;
   int busy_cnt = 0;
   int n_start = 0, n_en_on = 0, n_en_off = 0, n_done = 0, n_rxv_rise = 0;
   int cyc = 0, acc_cyc = 0, done_cyc = 0;
   logic rxv_prev = 1'b0;

   function automatic logic [7:0] flash_byte(input int p);
      logic [7:0] op;
      op = tx_hist[0];
      if (op == 8'h03 && p >= 4) return mem[8'(int'(tx_hist[3]) + p - 4)];
      if (op == 8'h0B && p >= 5) return mem[8'(int'(tx_hist[3]) + p - 5)];
      return fpat(p);
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (!reset_n) begin
         spi_ready <= 1'b1;
         busy_cnt  = 0;
         rxv_prev  = 1'b0;
      end else begin
         if (cmd_valid && cmd_ready) acc_cyc = cyc;
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (spi_enable_vld) begin
            if (spi_enable) begin
               n_en_on++;
               tx_hist.delete();
            end else begin
               n_en_off++;
            end
         end
         if (spi_tx_data_vld) tx_latch = spi_tx_data;
         if (spi_start) begin
            n_start++;
            tx_hist.push_back(tx_latch);
            rx_next   = flash_byte(tx_hist.size() - 1);
            busy_cnt  = B;
            spi_ready <= 1'b0;
         end else if (busy_cnt != 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
               spi_ready   <= 1'b1;
               spi_rx_data <= rx_next;
            end
         end
         if (rx_valid && rx_ready) rx_q.push_back(rx_data);
         if (rx_valid && !rxv_prev) n_rxv_rise++;
         rxv_prev = rx_valid;
      end
   end

   // Reference model: expected wire bytes and delivered bytes for one command.
   logic [7:0] exp_tx[$];
   logic [7:0] exp_rx[$];
   int base_start, base_on, base_off, base_done, base_rise;

   task automatic build_expect(input logic [7:0] op, input logic ae, input logic [23:0] addr,
                               input logic dm, input int len);
      int hdr;
      logic de;
      de  = dm && DUMMY_EN;
      hdr = 1 + (ae ? 3 : 0) + (de ? 1 : 0);
      exp_tx.delete();
      exp_rx.delete();
      exp_tx.push_back(op);
      if (ae) begin
         exp_tx.push_back(addr[23:16]);
         exp_tx.push_back(addr[15:8]);
         exp_tx.push_back(addr[7:0]);
      end
      if (de) exp_tx.push_back(8'h00);
      for (int k = 0; k < len; k++) begin
         exp_tx.push_back(8'h00);
         if ((op == 8'h03 || op == 8'h0B) && ae) exp_rx.push_back(mem[8'(int'(addr[7:0]) + k)]);
         else                                    exp_rx.push_back(fpat(hdr + k));
      end
   endtask

   task automatic start_cmd(input logic [7:0] op, input logic ae, input logic [23:0] addr,
                            input logic dm, input int len);
      logic ok;
      build_expect(op, ae, addr, dm, len);
      rx_q.delete();
      base_start = n_start;
      base_on    = n_en_on;
      base_off   = n_en_off;
      base_done  = n_done;
      base_rise  = n_rxv_rise;
      @(negedge clk);
      cmd_opcode  = op;
      cmd_addr_en = ae;
      cmd_addr    = addr;
      cmd_dummy   = dm;
      cmd_len     = LEN_W'(len);
      cmd_valid   = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(posedge clk);
         ok = cmd_ready;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      check("cmd_accept", 32'(ok), 32'd1);
   endtask

   task automatic finish_cmd(input string tag);
      for (int i = 0; i < 3000 && n_done == base_done; i++) @(negedge clk);
      check({tag, "_done"}, n_done - base_done, 1);
      @(negedge clk);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
      check({tag, "_n_start"}, n_start - base_start, exp_tx.size());
      check({tag, "_cs_on"}, n_en_on - base_on, 1);
      check({tag, "_cs_off"}, n_en_off - base_off, 1);
      check({tag, "_rxv_pulses"}, n_rxv_rise - base_rise, exp_rx.size());
      check({tag, "_tx_len"}, tx_hist.size(), exp_tx.size());
      for (int i = 0; i < exp_tx.size(); i++)
         check($sformatf("%s_tx%0d", tag, i),
               (i < tx_hist.size()) ? 32'(tx_hist[i]) : 32'hDEAD, 32'(exp_tx[i]));
      check({tag, "_rx_len"}, rx_q.size(), exp_rx.size());
      for (int i = 0; i < exp_rx.size(); i++)
         check($sformatf("%s_rx%0d", tag, i),
               (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD, 32'(exp_rx[i]));
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      check({tag, "_strobes"},
            32'({spi_enable, spi_enable_vld, spi_start, spi_tx_data_vld, done}), 32'd0);
   endtask

   initial begin
      logic [7:0] op;
      logic       ae, dm;
      int         len, s0, r;
      logic       seen;

      for (int i = 0; i < 256; i++) mem[i] = 8'((i * 7 + 3) ^ 8'h5C);
      mem[8'h45] = 8'hAA;
      mem[8'h46] = 8'hBB;
      mem[8'h47] = 8'hCC;
      mem[8'h48] = 8'hDD;

      reset_n     = 1'b0;
      fw_app_mode = 1'b0;
      cmd_valid   = 1'b0;
      cmd_opcode  = 8'h00;
      cmd_addr_en = 1'b0;
      cmd_addr    = 24'h0;
      cmd_dummy   = 1'b0;
      cmd_len     = '0;
      rx_ready    = 1'b1;

      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      check("reset_tx_data", 32'(spi_tx_data), 32'd0);
      check("reset_rx", 32'({rx_valid, rx_data}), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Opcode-only command and its latency.
      start_cmd(8'h06, 1'b0, 24'h0, 1'b0, 0);
      finish_cmd("wren");
      check("wren_latency", done_cyc - acc_cyc, 7 + B);

      start_cmd(8'h03, 1'b1, 24'h012345, 1'b0, 4);
      finish_cmd("read4");
      check("read4_rx0_lit", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD, 32'hAA);

      // Consumer stalls on the second byte.
      start_cmd(8'h03, 1'b1, 24'h012345, 1'b0, 4);
      for (int i = 0; i < 500 && rx_q.size() < 1; i++) @(negedge clk);
      rx_ready = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 500 && !seen; i++) begin
         @(negedge clk);
         seen = rx_valid;
      end
      check("stall_rxv_seen", 32'(seen), 32'd1);
      s0 = n_start;
      repeat (50) @(negedge clk);
      check("stall_no_start", n_start - s0, 0);
      check("stall_rxv_held", 32'(rx_valid), 32'd1);
      check("stall_rx_count", rx_q.size(), 1);
      rx_ready = 1'b1;
      finish_cmd("stall");

      // App mode refuses new commands but does not abort a running one.
      @(negedge clk);
      fw_app_mode = 1'b1;
      cmd_valid   = 1'b1;
      #1;
      check("app_cmd_ready", 32'(cmd_ready), 32'd0);
      s0 = n_en_on;
      r  = n_start;
      repeat (10) @(negedge clk);
      check("app_no_cs", n_en_on - s0, 0);
      check("app_no_start", n_start - r, 0);
      check("app_busy", 32'(busy), 32'd0);
      cmd_valid   = 1'b0;
      fw_app_mode = 1'b0;
      start_cmd(8'h03, 1'b1, 24'h000050, 1'b0, 3);
      for (int i = 0; i < 500 && n_start < base_start + 2; i++) @(negedge clk);
      fw_app_mode = 1'b1;
      finish_cmd("app_mid");
      check("app_mid_ready", 32'(cmd_ready), 32'd0);
      fw_app_mode = 1'b0;

      // Reset while waiting on the ADDR1 byte.
      start_cmd(8'h03, 1'b1, 24'hABCD10, 1'b0, 2);
      for (int i = 0; i < 500 && n_start < base_start + 3; i++) @(negedge clk);
      check("rst_reached_addr1", n_start - base_start, 3);
      repeat (4) @(negedge clk);
      check("rst_in_wait", 32'(busy), 32'd1);
      reset_n = 1'b0;
      @(negedge clk);
      check_idle_outputs("rst_mid");
      check("rst_mid_rxv", 32'(rx_valid), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

`ifdef TK1_SPI_SEQ_DUMMY_EN
      start_cmd(8'h0B, 1'b1, 24'h000100, 1'b1, 2);
      finish_cmd("fast_read");
`endif

      for (int t = 0; t < 12; t++) begin
         r   = $urandom_range(0, 3);
         len = $urandom_range(0, 5);
         op  = 8'($urandom);
         ae  = 1'($urandom);
         dm  = 1'($urandom);
         if (op == 8'h03 || op == 8'h0B) op = 8'hAB;
         case (r)
            0: begin op = 8'h03; ae = 1'b1; dm = 1'b0; end
            1: if (DUMMY_EN) begin op = 8'h0B; ae = 1'b1; dm = 1'b1; end
               else begin op = 8'h9F; ae = 1'b0; end
            2: begin op = 8'h9F; ae = 1'b0; end
            default: ;
         endcase
         start_cmd(op, ae, 24'($urandom), dm, len);
         finish_cmd($sformatf("rnd%0d", t));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
